// File: rtl/thermo_pkg.sv
// Shared helpers for LED level meters: bar/dot pattern builders and display mode codes.
package thermo_pkg;

  localparam int MAX_W = 64;

  localparam logic MODE_BAR = 1'b0;
  localparam logic MODE_DOT = 1'b1;

  // Callers size-cast the MAX_W-wide result down to their own bar width.
  function automatic logic [MAX_W-1:0] thermo(input int lvl);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[i] = (i <= lvl);
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] onehot(input int lvl);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) r[i] = (i == lvl);
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one clock out of every DIV, on the last count.
// tick is combinational from the count register; DIV=1 gives a permanent tick.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/thermo_bar_meter.sv
// Thermometer/dot LED meter with immediate attack, prescaled linear decay and held peak marker.
// level_o/peak_o update on the sampling edge; bar_o follows one clock later.
module thermo_bar_meter
  import thermo_pkg::*;
#(
  parameter  int IN_W       = 3,
  parameter  int DECAY_DIV  = 4,
  parameter  int HOLD_TICKS = 2,
  localparam int OUT_W      = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_value,
  output logic [OUT_W-1:0] bar_o,
  output logic [IN_W-1:0]  level_o,
  output logic [IN_W-1:0]  peak_o
);

  localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);

  logic              tick;
  logic [IN_W-1:0]   level_q, level_d, dec;
  logic [IN_W-1:0]   peak_q, peak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [OUT_W-1:0]  bar_q, bar_d;

  tick_prescaler #(.DIV(DECAY_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    dec     = (tick && level_q != '0) ? level_q - IN_W'(1) : level_q;
    level_d = (in_valid && in_value > dec) ? in_value : dec;

    peak_d = peak_q;
    hold_d = hold_q;
    // A fresh capture restarts the hold window, even on a tick cycle.
    if (in_valid && in_value >= peak_q) begin
      peak_d = in_value;
      hold_d = HOLD_INIT;
    end else if (tick && hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else if (tick && peak_q > level_d) begin
      peak_d = peak_q - IN_W'(1);
    end
    if (level_d > peak_d) peak_d = level_d;

    bar_d = '0;
    if (en) begin
      if (mode == MODE_DOT) bar_d = OUT_W'(onehot(int'(level_q)) | onehot(int'(peak_q)));
      else                  bar_d = OUT_W'(thermo(int'(level_q)) | onehot(int'(peak_q)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
      bar_q   <= '0;
    end else begin
      level_q <= level_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      bar_q   <= bar_d;
    end
  end

  assign bar_o   = bar_q;
  assign level_o = level_q;
  assign peak_o  = peak_q;

endmodule

// File: tb/tb_thermo_bar_meter.sv
// Bench for thermo_bar_meter: directed vector table, corner sequences and a modelled random run.
module tb_thermo_bar_meter;

  typedef struct {
    logic       rst, en, mode, vld;
    logic [2:0] val;
    logic [2:0] lvl, pk;
    logic [7:0] bar;
  } vec_t;

  typedef struct {
    logic [2:0] lvl, pk;
    logic [7:0] bar;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b1, mode = 1'b0, in_valid = 1'b0;
  logic [2:0] in_value = '0;
  logic [7:0] bar_o;
  logic [2:0] level_o, peak_o;

  logic       rst1 = 1'b1, vld1 = 1'b0;
  logic [2:0] val1 = '0;
  logic [7:0] bar1;
  logic [2:0] lvl1, pk1;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t vecs[38];

  always #5 clk = ~clk;

  thermo_bar_meter #(.IN_W(3), .DECAY_DIV(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_value(in_value),
    .bar_o(bar_o), .level_o(level_o), .peak_o(peak_o)
  );

  thermo_bar_meter #(.IN_W(3), .DECAY_DIV(1), .HOLD_TICKS(2)) dut1 (
    .clk(clk), .rst(rst1), .en(1'b1), .mode(1'b0), .in_valid(vld1), .in_value(val1),
    .bar_o(bar1), .level_o(lvl1), .peak_o(pk1)
  );

  function automatic vec_t mk(input logic r, e, m, v, input logic [2:0] val,
                              input logic [2:0] lvl, pk, input logic [7:0] b);
    vec_t x;
    x.rst = r; x.en = e; x.mode = m; x.vld = v; x.val = val;
    x.lvl = lvl; x.pk = pk; x.bar = b;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, e, m, v, input logic [2:0] val, input exp_t ex);
    exp_t got;
    rst = r; en = e; mode = m; in_valid = v; in_value = val;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue, got level %0d", level_o);
    end else begin
      got = sb.pop_front();
      chk("level", {5'b0, level_o}, {5'b0, got.lvl});
      chk("peak",  {5'b0, peak_o},  {5'b0, got.pk});
      chk("bar",   bar_o, got.bar);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t ex;
    int m_lvl, m_pk, m_hold, m_cnt, nl, np, nh, nb, dec;
    logic r, e, m, v;
    logic [2:0] val;
    logic tick;

    //             rst en md vld val  lvl pk  bar
    vecs[0]  = mk(1, 1, 0, 0, 0,  0, 0, 8'h00);
    vecs[1]  = mk(1, 1, 0, 0, 0,  0, 0, 8'h00);
    vecs[2]  = mk(0, 1, 0, 0, 0,  0, 0, 8'h01);
    vecs[3]  = mk(0, 1, 0, 1, 5,  5, 5, 8'h01);
    vecs[4]  = mk(0, 1, 0, 0, 0,  5, 5, 8'h3F);
    vecs[5]  = mk(0, 1, 0, 0, 0,  4, 5, 8'h3F);
    vecs[6]  = mk(0, 1, 0, 0, 0,  4, 5, 8'h3F);
    vecs[7]  = mk(0, 1, 0, 0, 0,  4, 5, 8'h3F);
    vecs[8]  = mk(0, 1, 0, 0, 0,  4, 5, 8'h3F);
    vecs[9]  = mk(0, 1, 0, 0, 0,  3, 5, 8'h3F);
    vecs[10] = mk(0, 1, 0, 0, 0,  3, 5, 8'h2F);
    vecs[11] = mk(0, 1, 0, 0, 0,  3, 5, 8'h2F);
    vecs[12] = mk(0, 1, 0, 0, 0,  3, 5, 8'h2F);
    vecs[13] = mk(0, 1, 0, 0, 0,  2, 4, 8'h2F);
    vecs[14] = mk(0, 1, 0, 0, 0,  2, 4, 8'h17);
    vecs[15] = mk(0, 1, 0, 1, 5,  5, 5, 8'h17);
    vecs[16] = mk(0, 1, 0, 0, 0,  5, 5, 8'h3F);
    vecs[17] = mk(0, 1, 0, 1, 3,  4, 5, 8'h3F);
    vecs[18] = mk(0, 1, 0, 1, 5,  5, 5, 8'h3F);
    vecs[19] = mk(0, 1, 0, 0, 0,  5, 5, 8'h3F);
    vecs[20] = mk(0, 1, 0, 0, 0,  5, 5, 8'h3F);
    vecs[21] = mk(0, 1, 0, 1, 6,  6, 6, 8'h3F);
    vecs[22] = mk(0, 1, 0, 0, 0,  6, 6, 8'h7F);
    vecs[23] = mk(0, 1, 0, 0, 0,  6, 6, 8'h7F);
    vecs[24] = mk(0, 1, 0, 0, 0,  6, 6, 8'h7F);
    vecs[25] = mk(0, 1, 0, 0, 0,  5, 6, 8'h7F);
    vecs[26] = mk(0, 1, 0, 0, 0,  5, 6, 8'h7F);
    vecs[27] = mk(0, 1, 0, 0, 0,  5, 6, 8'h7F);
    vecs[28] = mk(0, 1, 0, 0, 0,  5, 6, 8'h7F);
    vecs[29] = mk(0, 1, 0, 0, 0,  4, 6, 8'h7F);
    vecs[30] = mk(0, 1, 0, 0, 0,  4, 6, 8'h5F);
    vecs[31] = mk(0, 1, 1, 0, 0,  4, 6, 8'h50);
    vecs[32] = mk(0, 0, 0, 0, 0,  4, 6, 8'h00);
    vecs[33] = mk(0, 0, 0, 0, 0,  3, 5, 8'h00);
    vecs[34] = mk(0, 1, 0, 0, 0,  3, 5, 8'h2F);
    vecs[35] = mk(0, 1, 0, 1, 7,  7, 7, 8'h2F);
    vecs[36] = mk(1, 1, 0, 1, 7,  0, 0, 8'h00);
    vecs[37] = mk(0, 1, 0, 0, 0,  0, 0, 8'h01);

    for (int i = 0; i < 38; i++) begin
      ex.lvl = vecs[i].lvl; ex.pk = vecs[i].pk; ex.bar = vecs[i].bar;
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].vld, vecs[i].val, ex);
    end

    // Level already at 0: several ticks go by and nothing may wrap.
    ex.lvl = 0; ex.pk = 0; ex.bar = 8'h01;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, ex);

    // DECAY_DIV=1: full-scale sample then one step down per clock.
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0; vld1 = 1'b1; val1 = 3'd7;
    @(posedge clk); #1;
    vld1 = 1'b0;
    chk("div1_attack", {5'b0, lvl1}, 8'd7);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      chk("div1_decay", {5'b0, lvl1}, (i >= 7) ? 8'd0 : 8'(7 - i));
      checks++;
      if (pk1 < lvl1) begin
        errors++;
        $display("FAIL div1_peak_ge_level: peak %0d below level %0d", pk1, lvl1);
      end
    end

    // Modelled random run; the first cycle is a reset to align the model.
    m_lvl = 0; m_pk = 0; m_hold = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      r   = (c == 0) || ($urandom_range(0, 59) == 0);
      e   = ($urandom_range(0, 9) != 0);
      m   = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) == 0);
      val = 3'($urandom_range(0, 7));
      tick = (m_cnt == 3);
      if (r) begin
        nl = 0; np = 0; nh = 0; nb = 0; m_cnt = 0;
      end else begin
        dec = (tick && m_lvl > 0) ? m_lvl - 1 : m_lvl;
        nl = (v && int'(val) > dec) ? int'(val) : dec;
        np = m_pk; nh = m_hold;
        if (v && int'(val) >= m_pk) begin
          np = int'(val); nh = 2;
        end else if (tick) begin
          if (m_hold > 0) nh = m_hold - 1;
          else if (m_pk > nl) np = m_pk - 1;
        end
        if (nl > np) np = nl;
        if (!e)     nb = 0;
        else if (m) nb = (1 << m_lvl) | (1 << m_pk);
        else        nb = ((1 << (m_lvl + 1)) - 1) | (1 << m_pk);
        m_cnt = tick ? 0 : m_cnt + 1;
      end
      m_lvl = nl; m_pk = np; m_hold = nh;
      ex.lvl = 3'(nl); ex.pk = 3'(np); ex.bar = 8'(nb);
      step(r, e, m, v, val, ex);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
